// File: rtl/fft_pkg.sv
// Shared constants, sample type, reader states and bit-reversal helper for the FFT output path.
package fft_pkg;

  localparam int NBITS_OUT = 15;
  localparam int N_DFLT    = 32;
  localparam int LOG2N     = $clog2(N_DFLT);

  typedef struct packed {
    logic [NBITS_OUT-1:0] re;
    logic [NBITS_OUT-1:0] im;
  } cplx_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Reverses the low nb bits of v; bits above nb come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int nb);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < nb; i++) begin
      r[4'(i)] = v[4'(nb - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One reorder bank: N-entry RAM with four write ports and one registered, enabled read port.
module fft_reorder_bank #(
  parameter int W  = 30,
  parameter int AW = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [3:0][AW-1:0]   waddr_i,
  input  logic [3:0][W-1:0]    wdata_i,
  input  logic                 rd_en_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [W-1:0]         rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  // All four lanes of a beat land in distinct addresses, so the writes never collide.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[waddr_i[k]] <= wdata_i[k];
      end
    end
  end

  // Read register holds its value while not enabled, which keeps a stalled output stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_out_reorder.sv
// Bit-reversed to natural-order reorder buffer: 4 lanes in per beat, one bin out per cycle.
module fft_out_reorder #(
  parameter int NBITS_OUT = fft_pkg::NBITS_OUT,
  parameter int N         = fft_pkg::N_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2*NBITS_OUT-1:0]   in0_up,
  input  logic [2*NBITS_OUT-1:0]   in0_down,
  input  logic [2*NBITS_OUT-1:0]   in1_up,
  input  logic [2*NBITS_OUT-1:0]   in1_down,
  output logic [2*NBITS_OUT-1:0]   out_data,
  output logic [$clog2(N)-1:0]     out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     overflow
);
  import fft_pkg::*;

  localparam int AW  = $clog2(N);
  localparam int W   = 2 * NBITS_OUT;
  localparam int WCW = AW - 2;
  localparam logic [WCW-1:0] WC_LAST  = WCW'(N / 4 - 1);
  localparam logic [AW-1:0]  IDX_LAST = AW'(N - 1);

  logic [WCW-1:0] wc_q, wc_d;
  logic           wp_q, cur_bank_q, frame_ok_q, done_q, done_bank_q, overflow_q;
  logic [1:0]     full_q;
  rd_state_e      state_q;
  logic           rb_q, out_bank_q, out_valid_q, out_last_q;
  logic [AW-1:0]  fp_q, out_index_q;

  logic             hs_last_s, accept_s, we_s, wr_bank_s, load_s, fetch_s;
  logic [1:0]       rel_s;
  logic [AW-1:0]    fetch_addr_s;
  logic [3:0][AW-1:0] waddr_s;
  logic [3:0][W-1:0]  wdata_s;
  logic [W-1:0]     rdata0_s, rdata1_s;

  assign wdata_s = {in1_down, in1_up, in0_down, in0_up};

  for (genvar k = 0; k < 4; k++) begin : g_waddr
    assign waddr_s[k] = AW'(bitrev(16'({wc_q, 2'(k)}), AW));
  end

  // Write-side and reader-side decisions for the coming edge.
  always_comb begin
    wc_d         = (wc_q == WC_LAST) ? '0 : wc_q + WCW'(1);
    hs_last_s    = out_valid_q && out_ready && out_last_q;
    rel_s        = {hs_last_s && out_bank_q, hs_last_s && !out_bank_q};
    accept_s     = !full_q[wp_q] || rel_s[wp_q];
    wr_bank_s    = (wc_q == '0) ? wp_q : cur_bank_q;
    if (wc_q == '0) begin
      we_s = in_valid && accept_s;
    end else begin
      we_s = in_valid && frame_ok_q;
    end
    load_s       = !out_valid_q || out_ready;
    fetch_s      = load_s && ((state_q == RD_IDLE && full_q[rb_q]) || state_q == RD_READ);
    fetch_addr_s = (state_q == RD_IDLE) ? '0 : fp_q;
  end

  // Beat counter and per-frame bank choice; a refused frame is still counted through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wc_q        <= '0;
      wp_q        <= 1'b0;
      cur_bank_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      done_q      <= 1'b0;
      done_bank_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (in_valid) begin
        wc_q <= wc_d;
        if (wc_q == '0) begin
          frame_ok_q <= accept_s;
          if (accept_s) begin
            cur_bank_q <= wp_q;
            wp_q       <= ~wp_q;
          end else begin
            overflow_q <= 1'b1;
          end
        end
      end
      done_q      <= we_s && (wc_q == WC_LAST);
      done_bank_q <= wr_bank_s;
    end
  end

  // Full flags: set one cycle after a frame's last write, cleared by the final read handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (rel_s[b]) begin
          full_q[b] <= 1'b0;
        end else if (done_q && (done_bank_q == 1'(b))) begin
          full_q[b] <= 1'b1;
        end
      end
    end
  end

  // Reader FSM plus output register; fetches run one bin ahead so banks chain without bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RD_IDLE;
      rb_q        <= 1'b0;
      fp_q        <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_bank_q  <= 1'b0;
    end else begin
      if (load_s) begin
        out_valid_q <= fetch_s;
        out_last_q  <= fetch_s && (fetch_addr_s == IDX_LAST);
        if (fetch_s) begin
          out_index_q <= fetch_addr_s;
          out_bank_q  <= rb_q;
        end
      end
      if (fetch_s) begin
        case (state_q)
          RD_IDLE: begin
            state_q <= RD_READ;
            fp_q    <= AW'(1);
          end
          RD_READ: begin
            if (fp_q == IDX_LAST) begin
              rb_q    <= ~rb_q;
              fp_q    <= '0;
              state_q <= full_q[~rb_q] ? RD_READ : RD_IDLE;
            end else begin
              fp_q <= fp_q + AW'(1);
            end
          end
          default: state_q <= RD_IDLE;
        endcase
      end
    end
  end

  fft_reorder_bank #(.W(W), .AW(AW)) u_bank0 (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (we_s && !wr_bank_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .rd_en_i (fetch_s && !rb_q),
    .raddr_i (fetch_addr_s),
    .rdata_o (rdata0_s)
  );

  fft_reorder_bank #(.W(W), .AW(AW)) u_bank1 (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (we_s && wr_bank_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .rd_en_i (fetch_s && rb_q),
    .raddr_i (fetch_addr_s),
    .rdata_o (rdata1_s)
  );

  assign out_data  = out_bank_q ? rdata1_s : rdata0_s;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench: a frame-level reference model predicts every emitted bin, drops and overflow.
module tb_fft_out_reorder;
  import fft_pkg::*;

  localparam int N  = 32;
  localparam int NB = 15;
  localparam int W  = 2 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in0_up = '0, in0_down = '0, in1_up = '0, in1_down = '0;
  logic [W-1:0] out_data;
  logic [4:0]   out_index;
  logic         out_valid, out_ready = 1'b0, out_last, overflow;

  fft_out_reorder #(.NBITS_OUT(NB), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in0_up(in0_up), .in0_down(in0_down), .in1_up(in1_up), .in1_down(in1_down),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int pat = 0;

  typedef struct { int idx; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];

  function automatic int bitrev5(input int v);
    int r = 0;
    for (int i = 0; i < 5; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // out_ready patterns: 0 always, 1 never, 2 toggling 1,0,0,1, 3 random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      2: begin out_ready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference model: frames in natural order, at most two held, a frame released by its bin-31 handshake.
  int held = 0, wc_m = 0;
  bit acc_m = 0, ovf_m = 0, prev_stall = 0, rel;
  logic [W-1:0] prev_data;
  logic [4:0]   prev_idx;
  logic [W-1:0] fbuf [N];
  logic [W-1:0] lane [4];
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      held = 0; wc_m = 0; acc_m = 0; ovf_m = 0; prev_stall = 0;
    end else begin
      chk("overflow", overflow, ovf_m);
      chk("out_last", out_last, out_valid && (out_index == 5'd31));
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
        chk("hold_index", out_index, prev_idx);
      end
      rel = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_index, 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_index", out_index, e.idx);
          chk("out_data", out_data, e.data);
          rel = (e.idx == N - 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
      if (in_valid) begin
        if (wc_m == 0) begin
          acc_m = (held < 2) || rel;
          if (acc_m) held++;
          else ovf_m = 1;
        end
        lane[0] = in0_up; lane[1] = in0_down; lane[2] = in1_up; lane[3] = in1_down;
        for (int k = 0; k < 4; k++) fbuf[bitrev5(4 * wc_m + k)] = lane[k];
        if (wc_m == N / 4 - 1 && acc_m) begin
          for (int b = 0; b < N; b++) exp_q.push_back('{idx: b, data: fbuf[b]});
        end
        wc_m = (wc_m + 1) % (N / 4);
      end
      if (rel) held--;
    end
  end

  task automatic drive_beat(input int c, input bit ramp);
    cplx_t s;
    logic [W-1:0] l [4];
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (ramp) begin
        s.re = NB'(4 * c + k);
        s.im = '0;
      end else begin
        s = cplx_t'(W'($urandom));
      end
      l[k] = s;
    end
    in_valid = 1'b1;
    in0_up = l[0]; in0_down = l[1]; in1_up = l[2]; in1_down = l[3];
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; in_valid = 1'b0; end
  endtask

  task automatic send_frame(input bit ramp);
    for (int c = 0; c < N / 4; c++) drive_beat(c, ramp);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    idle(2);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_index"}, out_index, '0);
    chk({tag, "_last"}, out_last, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    cplx_t o;
    int w;
    do_reset("rst0");

    // Ramp frame: bin i must carry re = bitrev5(i), first valid two edges after beat 7.
    ready_mode = 0;
    send_frame(1'b1);
    idle(1);
    @(negedge clk); chk("lat_edge1", out_valid, 1'b0);
    @(negedge clk); chk("lat_edge2", out_valid, 1'b0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      o = cplx_t'(out_data);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_index", out_index, i);
      chk("t1_re", o.re, bitrev5(i));
      chk("t1_last", out_last, i == N - 1);
    end
    idle(4);
    chk("t1_drained", exp_q.size(), 0);

    // Two back-to-back frames: 64 bins without a gap.
    fork
      begin
        send_frame(1'b0);
        send_frame(1'b0);
        idle(1);
      end
      begin
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 40) begin @(negedge clk); w++; end
        chk("t2_start", out_valid, 1'b1);
        for (int i = 1; i < 2 * N; i++) begin
          @(negedge clk);
          chk("t2_nogap", out_valid, 1'b1);
        end
      end
    join
    idle(6);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_ovf", overflow, 1'b0);

    // Three frames into a stalled reader: the third is dropped, the first two survive.
    ready_mode = 1;
    idle(2);
    send_frame(1'b0);
    send_frame(1'b0);
    drive_beat(0, 1'b0);
    @(negedge clk); chk("t3_ovf_before", overflow, 1'b0);
    for (int c = 1; c < N / 4; c++) drive_beat(c, 1'b0);
    idle(1);
    chk("t3_ovf_after", overflow, 1'b1);
    chk("t3_pending", exp_q.size(), 2 * N);
    idle(3);
    ready_mode = 0;
    idle(75);
    chk("t3_drained", exp_q.size(), 0);

    // Ready toggling 1,0,0,1 with both banks in use.
    do_reset("rst1");
    ready_mode = 2;
    send_frame(1'b0);
    send_frame(1'b0);
    idle(150);
    chk("t4_drained", exp_q.size(), 0);

    // Reset at beat 3 with a stalled frame buffered; then a clean frame.
    ready_mode = 1;
    idle(2);
    send_frame(1'b0);
    for (int c = 0; c < 3; c++) drive_beat(c, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_data", out_data, '0);
    chk("t5_index", out_index, '0);
    chk("t5_last", out_last, 1'b0);
    chk("t5_ovf", overflow, 1'b0);
    idle(2);
    rst = 1'b1;
    ready_mode = 0;
    send_frame(1'b1);
    idle(45);
    chk("t5_drained", exp_q.size(), 0);

    // Random gaps and random ready; drops are legal and predicted by the model.
    ready_mode = 3;
    for (int f = 0; f < 30; f++) begin
      for (int c = 0; c < N / 4; c++) begin
        idle($urandom_range(0, 4));
        drive_beat(c, 1'b0);
      end
    end
    idle(1);
    ready_mode = 0;
    idle(120);
    chk("t6_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer for the 4-lane parallel FFT datapath. It consumes the four saturated complex outputs per cycle, which arrive in bit-reversed bin order. It emits one complex sample per cycle in natural bin order over a valid/ready stream. It sits directly after the output saturators of the FFT top and is the reader side of the FFT output interface.

## Interface
Parameters:
- NBITS_OUT, 15, bits per real/imag component (Q3.12).
- N, 32, FFT size; power of two, ≥ 8.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  all four lanes valid this cycle; the input cannot be stalled.
- in0_up  in  2*NBITS_OUT  lane 0, {re, im}.
- in0_down  in  2*NBITS_OUT  lane 1.
- in1_up  in  2*NBITS_OUT  lane 2.
- in1_down  in  2*NBITS_OUT  lane 3.
- out_data  out  2*NBITS_OUT  {re, im} of the current bin.
- out_index  out  log2(N)  bin number of out_data.
- out_valid  out  1  out_data/out_index/out_last valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  high with bin N-1.
- overflow  out  1  sticky; a frame was dropped.

## Operation
- Frame = N/4 input beats. A write beat counter wc (0..N/4-1) advances on each in_valid and wraps to 0 after N/4-1.
- Lane k at beat wc carries bin bitrev(4*wc+k) over log2(N) bits. It is written to address bitrev(4*wc+k) of the current write bank.
- Two banks (ping-pong), each N x 2*NBITS_OUT. Each bank has a full flag.
- At beat wc=0 the writer selects the bank after the previously written one. The selected bank is accepted if it is not full, or if its final read handshake (index N-1) occurs in the same cycle. Otherwise the whole frame is dropped: all N/4 beats are counted but not written, and overflow is set.
- The full flag sets the cycle after the beat wc=N/4-1 write.
- Reader FSM states:
  - IDLE: wait for the oldest full bank, then go to READ with read address rd=0.
  - READ: present bin rd. Advance on out_valid && out_ready. After the handshake at rd=N-1, clear that bank's full flag. Then go to READ on the other bank if it is full, else IDLE.
- Banks are read in the order they were filled.
- Output register: loads when !out_valid || out_ready. out_data, out_index and out_valid are held stable while out_valid && !out_ready.
- out_last = out_valid && out_index == N-1.
- Data passes unmodified: no rounding or sign handling.

## Timing
- Reset values:
  - out_data 0, out_index 0, out_valid 0, out_last 0, overflow 0.
  - wc 0, both full flags 0, FSM IDLE, write-bank pointer selects bank 0 on the first frame.
- Latency: the last beat of a frame is sampled at edge t. The full flag is set at t+1. Bin 0 appears with out_valid at edge t+2 if the reader is idle. With out_ready held high, one bin is emitted per cycle with no bubbles, including across back-to-back banks.
- Sustained throughput: 4 samples in per beat, 1 out per cycle. The input must average ≤ 1 beat per 4 cycles, or frames drop.
- Release and refill in the same cycle is legal: beat 0 writes addresses 0, N/4, N/2, 3N/4, never N-1 (N ≥ 8).
- Reset mid-frame discards partial frames and buffered banks. The next in_valid after reset is beat 0.

## Structure
- Shared package fft_pkg: NBITS_OUT, LOG2N (derived from N), a bitrev function, and the complex sample typedef {re, im}.
- Sub-module fft_reorder_bank: simple dual-port RAM with one registered read port and four write ports. Instantiate it twice, or implement it as four lane-interleaved single-write RAMs addressed by the low two bits of bitrev.
- Top level holds the write counter, bank selection, full flags, reader FSM and output register.

## Test plan
- N=32, one frame where lane k at beat c carries re=4c+k, im=0, out_ready=1:
  - Output bins 0..31 on 32 consecutive cycles.
  - out_data re = bitrev5(index), out_last only on index 31.
  - First out_valid 2 cycles after beat 7.
- Two frames back-to-back (16 consecutive beats), out_ready=1:
  - 64 bins out with no gap between index 31 and the next index 0.
  - overflow stays 0.
- Three frames back-to-back, out_ready=0 throughout:
  - Frames 1–2 fill both banks; frame 3 is dropped.
  - overflow=1 from the cycle after its beat 0.
  - Raising out_ready then yields frames 1 and 2 intact.
- out_ready toggling 1,0,0,1 repeatedly: out_data/out_index hold while stalled, and no bin is repeated or skipped.
- Assert rst low at beat 3 of a frame, then release:
  - All outputs 0 and out_valid=0.
  - A new full frame is reordered correctly, with no residue from the partial frame.
